// File: rtl/crc32_byte_feeder.sv
// crc32_byte_feeder: upstream stage of the CRC-32 byte engine.
// Buffers 32-bit message words in a small FIFO, serialises them into bytes
// and drives the engine trigger/byte/done handshake one byte per pass.
// On the last byte of a message the final CRC is captured before data_done
// releases the engine, because the engine re-initialises its CRC in IDLE.
// Optional feature: define CRC32_FEEDER_MSB_FIRST_EN to add the msb_first
// input (per-word most-significant-byte-first serialisation).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no word in flight; waits for the FIFO to become non-empty
// LOAD    | pops the FIFO head into the holding register, idx = 0
// TRIG    | one-cycle crc_trigger with the current byte on crc_byte
// WAIT    | byte held stable until the engine's crc_done_pulse
// STALL   | mid-message starvation; engine parked with partial CRC
// CAPTURE | latches crc_value into result, sets result_valid
// RELEASE | one-cycle data_done so the engine returns to IDLE

`timescale 1ns/1ps

module crc32_byte_feeder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    input  logic [1:0]  wr_bytes,
    input  logic        wr_last,
`ifdef CRC32_FEEDER_MSB_FIRST_EN
    input  logic        msb_first,
`endif
    input  logic        abort,
    output logic        crc_trigger,
    output logic [7:0]  crc_byte,
    output logic        data_done,
    input  logic        crc_busy,
    input  logic        crc_done_pulse,
    input  logic [31:0] crc_value,
    output logic        busy,
    output logic [31:0] result,
    output logic        result_valid
);

    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef CRC32_FEEDER_MSB_FIRST_EN
    localparam int EW = 36;
`else
    localparam int EW = 35;
`endif
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_TRIG,
        S_WAIT,
        S_STALL,
        S_CAPTURE,
        S_RELEASE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [EW-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [EW-1:0] r_hold;
    logic [1:0]    r_idx;
    logic          r_abort_pend;

    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic [EW-1:0] w_wr_entry;
    logic [EW-1:0] w_head;
    logic [31:0]   w_hold_data;
    logic [1:0]    w_hold_bytes;
    logic          w_hold_last;
    logic          w_more_bytes;

    // Entry layout: {[msb_first,] last, bytes, data}
`ifdef CRC32_FEEDER_MSB_FIRST_EN
    assign w_wr_entry = {msb_first, wr_last, wr_bytes, wr_data};
`else
    assign w_wr_entry = {wr_last, wr_bytes, wr_data};
`endif

    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // Abort flushes the FIFO, so nothing may be accepted in that cycle.
    assign wr_ready = !w_full && !abort;
    assign w_push   = wr_valid && wr_ready;
    assign w_pop    = (r_state == S_LOAD) && !abort;
    assign w_head   = r_mem[r_rd_ptr[AW-1:0]];

    assign w_hold_data  = r_hold[31:0];
    assign w_hold_bytes = r_hold[33:32];
    assign w_hold_last  = r_hold[34];
    assign w_more_bytes = (r_idx < w_hold_bytes);

    assign busy = (r_state != S_IDLE) || !w_empty;

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_wr_entry;
        end
    end

    // FIFO pointers; abort collapses the read pointer onto the write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (abort) begin
            r_rd_ptr <= r_wr_ptr;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and handshake pulses. The trigger is also gated on
    // crc_busy so a slow engine can never see a trigger mid-pass.
    always_comb begin
        w_state_nxt = r_state;
        crc_trigger = 1'b0;
        data_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!abort && !w_empty) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_state_nxt = abort ? S_RELEASE : S_TRIG;
            end
            S_TRIG: begin
                if (!crc_busy) begin
                    crc_trigger = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (crc_done_pulse) begin
                    if (abort || r_abort_pend) w_state_nxt = S_RELEASE;
                    else if (w_more_bytes)     w_state_nxt = S_TRIG;
                    else if (w_hold_last)      w_state_nxt = S_CAPTURE;
                    else if (!w_empty)         w_state_nxt = S_LOAD;
                    else                       w_state_nxt = S_STALL;
                end
            end
            S_STALL: begin
                if (abort)         w_state_nxt = S_RELEASE;
                else if (!w_empty) w_state_nxt = S_LOAD;
            end
            S_CAPTURE: begin
                w_state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                data_done   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Holding register and byte index for the word being serialised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= '0;
            r_idx  <= 2'd0;
        end else if (w_pop) begin
            r_hold <= w_head;
            r_idx  <= 2'd0;
        end else if ((r_state == S_WAIT) && crc_done_pulse && !abort &&
                     !r_abort_pend && w_more_bytes) begin
            r_idx <= r_idx + 2'd1;
        end
    end

    // Remembers an abort seen while a pass is in flight so WAIT can finish
    // the pass and then skip CAPTURE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_abort_pend <= 1'b0;
        end else if (r_state == S_RELEASE) begin
            r_abort_pend <= 1'b0;
        end else if (abort && ((r_state == S_TRIG) || (r_state == S_WAIT))) begin
            r_abort_pend <= 1'b1;
        end
    end

    // Final CRC capture; an abort in CAPTURE suppresses it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result       <= 32'd0;
            result_valid <= 1'b0;
        end else if ((r_state == S_CAPTURE) && !abort) begin
            result       <= crc_value;
            result_valid <= 1'b1;
        end else if (abort || w_push) begin
            result_valid <= 1'b0;
        end
    end

    // Byte selection for crc_byte; stable while hold and idx are stable.
    always_comb begin
        crc_byte = w_hold_data[7:0];
`ifdef CRC32_FEEDER_MSB_FIRST_EN
        if (r_hold[35]) begin
            case (r_idx)
                2'd0:    crc_byte = w_hold_data[31:24];
                2'd1:    crc_byte = w_hold_data[23:16];
                2'd2:    crc_byte = w_hold_data[15:8];
                default: crc_byte = w_hold_data[7:0];
            endcase
        end else begin
            case (r_idx)
                2'd0:    crc_byte = w_hold_data[7:0];
                2'd1:    crc_byte = w_hold_data[15:8];
                2'd2:    crc_byte = w_hold_data[23:16];
                default: crc_byte = w_hold_data[31:24];
            endcase
        end
`else
        case (r_idx)
            2'd0:    crc_byte = w_hold_data[7:0];
            2'd1:    crc_byte = w_hold_data[15:8];
            2'd2:    crc_byte = w_hold_data[23:16];
            default: crc_byte = w_hold_data[31:24];
        endcase
`endif
    end

endmodule

// File: tb/tb_crc32_byte_feeder.sv
// Bench for crc32_byte_feeder: a behavioural CRC engine drives the handshake,
// and results are compared with a reference CRC over the expected byte list.

`timescale 1ns/1ps

module tb_crc32_byte_feeder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic [1:0]  wr_bytes;
    logic        wr_last;
`ifdef CRC32_FEEDER_MSB_FIRST_EN
    logic        msb_first;
`endif
    logic        abort;
    logic        crc_trigger;
    logic [7:0]  crc_byte;
    logic        data_done;
    logic        crc_busy;
    logic        crc_done_pulse;
    logic [31:0] crc_value;
    logic        busy;
    logic [31:0] result;
    logic        result_valid;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    crc32_byte_feeder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_data        (wr_data),
        .wr_bytes       (wr_bytes),
        .wr_last        (wr_last),
`ifdef CRC32_FEEDER_MSB_FIRST_EN
        .msb_first      (msb_first),
`endif
        .abort          (abort),
        .crc_trigger    (crc_trigger),
        .crc_byte       (crc_byte),
        .data_done      (data_done),
        .crc_busy       (crc_busy),
        .crc_done_pulse (crc_done_pulse),
        .crc_value      (crc_value),
        .busy           (busy),
        .result         (result),
        .result_valid   (result_valid)
    );

    // ---------------- engine model (MSB-first register, RefIn/RefOut) ----
    logic [3:0]  e_cnt;
    logic [31:0] e_reg;
    logic [7:0]  e_byte;
    bit          eng_hold = 1'b0;

    function automatic logic [31:0] bitrev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[31-i];
        return r;
    endfunction

    function automatic logic [31:0] eng_step(input logic [31:0] c, input logic [7:0] b);
        logic [7:0]  rb;
        logic [31:0] v;
        for (int i = 0; i < 8; i++) rb[i] = b[7-i];
        v = c ^ {rb, 24'h0};
        for (int k = 0; k < 8; k++) v = v[31] ? ((v << 1) ^ 32'h04C11DB7) : (v << 1);
        return v;
    endfunction

    assign crc_busy       = (e_cnt != 4'd0);
    assign crc_done_pulse = (e_cnt == 4'd1) && !eng_hold;
    assign crc_value      = ~bitrev32(e_reg);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_cnt  <= 4'd0;
            e_reg  <= 32'hFFFFFFFF;
            e_byte <= 8'd0;
        end else begin
            if (data_done) e_reg <= 32'hFFFFFFFF;
            if (crc_trigger) begin
                e_cnt  <= 4'd11;
                e_byte <= crc_byte;
            end else if (e_cnt != 4'd0 && !eng_hold) begin
                e_cnt <= e_cnt - 4'd1;
                if (e_cnt == 4'd1) e_reg <= eng_step(e_reg, e_byte);
            end
        end
    end

    // ---------------- handshake monitor ----------------
    int         cyc = 0;
    int         n_trig, n_done, n_dd, n_viol, last_done_cyc, dd_cyc;
    logic [7:0] trace [0:255];

    always @(posedge clk) begin
        cyc++;
        if (rst_n) begin
            if (crc_trigger) begin
                if (n_trig < 256) trace[n_trig] = crc_byte;
                n_trig++;
                if (crc_busy || data_done) n_viol++;
            end
            if (crc_busy && crc_byte !== e_byte) n_viol++;
            if (crc_done_pulse) begin
                n_done++;
                last_done_cyc = cyc;
            end
            if (data_done) begin
                n_dd++;
                dd_cyc = cyc;
            end
        end
    end

    task automatic clear_mon();
        n_trig = 0; n_done = 0; n_dd = 0; n_viol = 0;
        last_done_cyc = 0; dd_cyc = 0;
    endtask

    // ---------------- reference model: message as a byte list ----------
    logic [7:0] msg [0:255];
    int         msg_n;
    bit         push_tmo = 1'b0;

    task automatic add_word(input logic [31:0] d, input logic [1:0] b, input logic m);
        for (int k = 0; k <= int'(b); k++) begin
            msg[msg_n] = m ? 8'(d >> (24 - 8*k)) : 8'(d >> (8*k));
            msg_n++;
        end
    endtask

    function automatic logic [31:0] ref_crc(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, msg[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic push_word(input logic [31:0] d, input logic [1:0] b, input logic l, input logic m);
        int g;
        g = 0;
        @(negedge clk);
        wr_valid = 1'b1; wr_data = d; wr_bytes = b; wr_last = l;
`ifdef CRC32_FEEDER_MSB_FIRST_EN
        msb_first = m;
`endif
        #1;
        while (!wr_ready && g < 3000) begin
            @(negedge clk); #1; g++;
        end
        if (g >= 3000) push_tmo = 1'b1;
        else           add_word(d, b, m);
        @(posedge clk); #1;
        wr_valid = 1'b0; wr_last = 1'b0;
    endtask

    task automatic wait_dd(input int target, output bit ok);
        int g;
        g = 0;
        while (n_dd < target && g < 5000) begin
            @(posedge clk); g++;
        end
        ok = (n_dd >= target);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (wr_ready !== 1'b1)      begin n_mis++; $display("FAIL reset_wr_ready got %b exp 1", wr_ready); end
        n_cmp++; if (crc_trigger !== 1'b0)   begin n_mis++; $display("FAIL reset_trigger got %b exp 0", crc_trigger); end
        n_cmp++; if (crc_byte !== 8'h00)     begin n_mis++; $display("FAIL reset_crc_byte got %h exp 00", crc_byte); end
        n_cmp++; if (data_done !== 1'b0)     begin n_mis++; $display("FAIL reset_data_done got %b exp 0", data_done); end
        n_cmp++; if (busy !== 1'b0)          begin n_mis++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_cmp++; if (result !== 32'h0)       begin n_mis++; $display("FAIL reset_result got %h exp 0", result); end
        n_cmp++; if (result_valid !== 1'b0)  begin n_mis++; $display("FAIL reset_result_valid got %b exp 0", result_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL post_reset_busy got %b exp 0", busy); end
    endtask

    task automatic test_check_string();
        bit ok;
        clear_mon(); msg_n = 0;
        push_word(32'h34333231, 2'd3, 1'b0, 1'b0);
        push_word(32'h38373635, 2'd3, 1'b0, 1'b0);
        push_word(32'h00000039, 2'd0, 1'b1, 1'b0);
        wait_dd(1, ok);
        n_cmp++; if (ok !== 1'b1)              begin n_mis++; $display("FAIL chk_timeout got %b exp 1", ok); end
        n_cmp++; if (n_trig != 9)              begin n_mis++; $display("FAIL chk_triggers got %0d exp 9", n_trig); end
        n_cmp++; if (result !== 32'hCBF43926)  begin n_mis++; $display("FAIL chk_result got %h exp cbf43926", result); end
        n_cmp++; if (result_valid !== 1'b1)    begin n_mis++; $display("FAIL chk_result_valid got %b exp 1", result_valid); end
        n_cmp++; if (n_dd != 1)                begin n_mis++; $display("FAIL chk_data_done_count got %0d exp 1", n_dd); end
        n_cmp++; if (dd_cyc - last_done_cyc != 2) begin n_mis++; $display("FAIL chk_done_latency got %0d exp 2", dd_cyc - last_done_cyc); end
        for (int i = 0; i < 9; i++) begin
            n_cmp++; if (trace[i] !== msg[i]) begin n_mis++; $display("FAIL chk_byte%0d got %h exp %h", i, trace[i], msg[i]); end
        end
        n_cmp++; if (n_viol != 0)    begin n_mis++; $display("FAIL chk_contract got %0d exp 0", n_viol); end
        n_cmp++; if (busy !== 1'b0)  begin n_mis++; $display("FAIL chk_busy_end got %b exp 0", busy); end
    endtask

    task automatic test_fifo_full();
        bit ok;
        bit exp_rdy;
        clear_mon(); msg_n = 0;
        eng_hold = 1'b1;
        push_word($urandom, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        n_cmp++; if (wr_ready !== 1'b1) begin n_mis++; $display("FAIL full_ready_start got %b exp 1", wr_ready); end
        n_cmp++; if (n_trig != 1)       begin n_mis++; $display("FAIL full_first_trig got %0d exp 1", n_trig); end
        for (int k = 1; k <= DEPTH; k++) begin
            push_word($urandom, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
            exp_rdy = (k < DEPTH);
            n_cmp++; if (wr_ready !== exp_rdy) begin n_mis++; $display("FAIL full_ready_after_%0d got %b exp %b", k, wr_ready, exp_rdy); end
        end
        fork
            push_word($urandom, 2'($urandom_range(0, 3)), 1'b1, 1'b0);
            begin
                repeat (20) @(posedge clk);
                eng_hold = 1'b0;
            end
        join
        wait_dd(1, ok);
        n_cmp++; if (ok !== 1'b1)     begin n_mis++; $display("FAIL full_timeout got %b exp 1", ok); end
        n_cmp++; if (n_trig != msg_n) begin n_mis++; $display("FAIL full_triggers got %0d exp %0d", n_trig, msg_n); end
        for (int i = 0; i < msg_n; i++) begin
            n_cmp++; if (trace[i] !== msg[i]) begin n_mis++; $display("FAIL full_byte%0d got %h exp %h", i, trace[i], msg[i]); end
        end
        n_cmp++; if (result !== ref_crc(msg_n)) begin n_mis++; $display("FAIL full_result got %h exp %h", result, ref_crc(msg_n)); end
        n_cmp++; if (result_valid !== 1'b1)     begin n_mis++; $display("FAIL full_result_valid got %b exp 1", result_valid); end
        n_cmp++; if (n_viol != 0)               begin n_mis++; $display("FAIL full_contract got %0d exp 0", n_viol); end
    endtask

    task automatic test_starvation();
        bit ok;
        clear_mon(); msg_n = 0;
        push_word($urandom, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
        repeat (100) @(posedge clk);
        #1;
        n_cmp++; if (n_dd != 0)             begin n_mis++; $display("FAIL starve_no_done got %0d exp 0", n_dd); end
        n_cmp++; if (busy !== 1'b1)         begin n_mis++; $display("FAIL starve_busy got %b exp 1", busy); end
        n_cmp++; if (result_valid !== 1'b0) begin n_mis++; $display("FAIL starve_rv_cleared got %b exp 0", result_valid); end
        n_cmp++; if (n_trig != msg_n)       begin n_mis++; $display("FAIL starve_partial_trig got %0d exp %0d", n_trig, msg_n); end
        push_word($urandom, 2'($urandom_range(0, 3)), 1'b1, 1'b0);
        wait_dd(1, ok);
        n_cmp++; if (ok !== 1'b1)     begin n_mis++; $display("FAIL starve_timeout got %b exp 1", ok); end
        n_cmp++; if (n_trig != msg_n) begin n_mis++; $display("FAIL starve_triggers got %0d exp %0d", n_trig, msg_n); end
        n_cmp++; if (result !== ref_crc(msg_n)) begin n_mis++; $display("FAIL starve_result got %h exp %h", result, ref_crc(msg_n)); end
        n_cmp++; if (n_dd != 1)       begin n_mis++; $display("FAIL starve_done_count got %0d exp 1", n_dd); end
        n_cmp++; if (n_viol != 0)     begin n_mis++; $display("FAIL starve_contract got %0d exp 0", n_viol); end
    endtask

    task automatic test_abort();
        bit          ok;
        int          g;
        logic [31:0] prev;
        clear_mon(); msg_n = 0;
        prev = result;
        push_word($urandom, 2'd3, 1'b0, 1'b0);
        push_word($urandom, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
        g = 0;
        while (n_trig < 3 && g < 200) begin
            @(posedge clk); g++;
        end
        n_cmp++; if (n_trig != 3) begin n_mis++; $display("FAIL abort_reach_byte2 got %0d exp 3", n_trig); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        abort = 1'b1; wr_valid = 1'b1; wr_data = $urandom; wr_bytes = 2'd3; wr_last = 1'b1;
        #1;
        n_cmp++; if (wr_ready !== 1'b0) begin n_mis++; $display("FAIL abort_wr_ready got %b exp 0", wr_ready); end
        @(posedge clk); #1;
        abort = 1'b0; wr_valid = 1'b0; wr_last = 1'b0;
        n_cmp++; if (n_dd != 0) begin n_mis++; $display("FAIL abort_early_done got %0d exp 0", n_dd); end
        wait_dd(1, ok);
        n_cmp++; if (ok !== 1'b1)   begin n_mis++; $display("FAIL abort_timeout got %b exp 1", ok); end
        n_cmp++; if (dd_cyc - last_done_cyc != 1) begin n_mis++; $display("FAIL abort_done_latency got %0d exp 1", dd_cyc - last_done_cyc); end
        n_cmp++; if (n_done != 3)   begin n_mis++; $display("FAIL abort_passes got %0d exp 3", n_done); end
        n_cmp++; if (n_trig != 3)   begin n_mis++; $display("FAIL abort_triggers got %0d exp 3", n_trig); end
        n_cmp++; if (result !== prev)       begin n_mis++; $display("FAIL abort_result_kept got %h exp %h", result, prev); end
        n_cmp++; if (result_valid !== 1'b0) begin n_mis++; $display("FAIL abort_rv got %b exp 0", result_valid); end
        n_cmp++; if (busy !== 1'b0)         begin n_mis++; $display("FAIL abort_fifo_flushed got %b exp 0", busy); end
        n_cmp++; if (n_viol != 0)           begin n_mis++; $display("FAIL abort_contract got %0d exp 0", n_viol); end
        clear_mon(); msg_n = 0;
        push_word($urandom, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
        push_word($urandom, 2'($urandom_range(0, 3)), 1'b1, 1'b0);
        wait_dd(1, ok);
        n_cmp++; if (ok !== 1'b1)               begin n_mis++; $display("FAIL after_abort_timeout got %b exp 1", ok); end
        n_cmp++; if (result !== ref_crc(msg_n)) begin n_mis++; $display("FAIL after_abort_result got %h exp %h", result, ref_crc(msg_n)); end
        n_cmp++; if (result_valid !== 1'b1)     begin n_mis++; $display("FAIL after_abort_rv got %b exp 1", result_valid); end
    endtask

    task automatic test_async_reset();
        int g;
        bit seen;
        clear_mon(); msg_n = 0;
        push_word($urandom, 2'd3, 1'b1, 1'b0);
        seen = 1'b0;
        g = 0;
        while (!seen && g < 50) begin
            @(posedge clk); #1;
            seen = crc_trigger;
            g++;
        end
        n_cmp++; if (seen !== 1'b1) begin n_mis++; $display("FAIL areset_reach_trig got %b exp 1", seen); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (crc_trigger !== 1'b0)  begin n_mis++; $display("FAIL areset_trigger got %b exp 0", crc_trigger); end
        n_cmp++; if (busy !== 1'b0)         begin n_mis++; $display("FAIL areset_busy got %b exp 0", busy); end
        n_cmp++; if (wr_ready !== 1'b1)     begin n_mis++; $display("FAIL areset_wr_ready got %b exp 1", wr_ready); end
        n_cmp++; if (crc_byte !== 8'h00)    begin n_mis++; $display("FAIL areset_crc_byte got %h exp 00", crc_byte); end
        n_cmp++; if (result !== 32'h0)      begin n_mis++; $display("FAIL areset_result got %h exp 0", result); end
        n_cmp++; if (result_valid !== 1'b0) begin n_mis++; $display("FAIL areset_rv got %b exp 0", result_valid); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

`ifdef CRC32_FEEDER_MSB_FIRST_EN
    task automatic test_msb_first();
        bit         ok;
        logic [7:0] exp_b [0:3];
        exp_b[0] = 8'h31; exp_b[1] = 8'h32; exp_b[2] = 8'h33; exp_b[3] = 8'h34;
        clear_mon(); msg_n = 0;
        push_word(32'h31323334, 2'd3, 1'b1, 1'b1);
        wait_dd(1, ok);
        n_cmp++; if (ok !== 1'b1) begin n_mis++; $display("FAIL msb_timeout got %b exp 1", ok); end
        n_cmp++; if (n_trig != 4) begin n_mis++; $display("FAIL msb_triggers got %0d exp 4", n_trig); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (trace[i] !== exp_b[i]) begin n_mis++; $display("FAIL msb_byte%0d got %h exp %h", i, trace[i], exp_b[i]); end
        end
        n_cmp++; if (result !== 32'h9BE3E0A3) begin n_mis++; $display("FAIL msb_result got %h exp 9be3e0a3", result); end
    endtask
`endif

    task automatic test_random();
        bit ok;
        int nw;
        int bad;
        logic m;
        for (int t = 0; t < 6; t++) begin
            clear_mon(); msg_n = 0;
            nw = $urandom_range(1, 3);
            for (int w = 0; w < nw; w++) begin
`ifdef CRC32_FEEDER_MSB_FIRST_EN
                m = 1'($urandom_range(0, 1));
`else
                m = 1'b0;
`endif
                push_word($urandom, 2'($urandom_range(0, 3)), (w == nw - 1), m);
            end
            wait_dd(1, ok);
            bad = 0;
            for (int i = 0; i < msg_n; i++) if (trace[i] !== msg[i]) bad++;
            n_cmp++; if (ok !== 1'b1)     begin n_mis++; $display("FAIL rand%0d_timeout got %b exp 1", t, ok); end
            n_cmp++; if (n_trig != msg_n) begin n_mis++; $display("FAIL rand%0d_triggers got %0d exp %0d", t, n_trig, msg_n); end
            n_cmp++; if (bad != 0)        begin n_mis++; $display("FAIL rand%0d_byte_order got %0d bad exp 0", t, bad); end
            n_cmp++; if (result !== ref_crc(msg_n)) begin n_mis++; $display("FAIL rand%0d_result got %h exp %h", t, result, ref_crc(msg_n)); end
            n_cmp++; if (result_valid !== 1'b1) begin n_mis++; $display("FAIL rand%0d_rv got %b exp 1", t, result_valid); end
            n_cmp++; if (n_dd != 1)       begin n_mis++; $display("FAIL rand%0d_done_count got %0d exp 1", t, n_dd); end
            n_cmp++; if (n_viol != 0)     begin n_mis++; $display("FAIL rand%0d_contract got %0d exp 0", t, n_viol); end
        end
        n_cmp++; if (push_tmo !== 1'b0) begin n_mis++; $display("FAIL push_timeout got %b exp 0", push_tmo); end
    endtask

    initial begin
        rst_n = 1'b0; wr_valid = 1'b0; wr_data = 32'h0; wr_bytes = 2'd0;
        wr_last = 1'b0; abort = 1'b0;
`ifdef CRC32_FEEDER_MSB_FIRST_EN
        msb_first = 1'b0;
`endif
        clear_mon(); msg_n = 0;
        test_reset();
        test_check_string();
        test_fifo_full();
        test_starvation();
        test_abort();
        test_async_reset();
`ifdef CRC32_FEEDER_MSB_FIRST_EN
        test_msb_first();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
